bit_serial_sched: RTL and testbench
===================================

Name: bit_serial_sched

Overview:
- Sequencer and arbiter for a bit-serial add/subtract datapath shared by two requesters.
- Arbitrates requests round-robin, latches the winner's operands, and runs WIDTH LSB-first serial add cycles.
- Pulses done with the result and the owner ID.
- Sits between client blocks and the serial adder resources. Shift registers, the 1-bit full adder and the carry flop are internal, so the block is self-contained.

Parameters:
- WIDTH, 8, operand/result width in bits; also the number of serial shift cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; held with operands until gnt0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- sub0  input  1  requester 0 op: 0 = A+B, 1 = A-B.
- req1, a1, b1, sub1  input  1/WIDTH/WIDTH/1  requester 1, same meaning as requester 0.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- busy  output  1  high while an operation is in flight (SHIFT or DONE state).
- done  output  1  one-cycle pulse: result valid.
- done_id  output  1  owner of the completed operation.
- sum  output  WIDTH  result; held until the next done.
- cout  output  1  final carry out (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; all outputs 0.
  - Internal A/B/S registers, carry and bit counter cleared.
  - last_served = 1, so requester 0 wins the first tie.
  - Takes effect immediately, including mid-operation. An aborted operation produces no done and no sum update.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - On an edge with req0|req1 asserted, the winner is:
    - the sole requester, or
    - if both request, the one not equal to last_served.
  - On that edge:
    - A <= a_w.
    - B <= sub_w ? ~b_w : b_w.
    - carry <= sub_w.
    - S <= 0, cnt <= 0, owner <= w.
    - gnt_w <= 1 for exactly the next cycle.
    - state <= SHIFT.
- SHIFT (one serial step per edge):
  - s_bit = A[0]^B[0]^carry.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right (zero fill); S shifts right with s_bit entering the MSB.
  - cnt increments.
  - On the edge where cnt == WIDTH-1 (the WIDTH-th shift), record the carry-in of the MSB step for ovf, and set state <= DONE.
- DONE (exactly one cycle):
  - done = 1; sum = S; cout = carry; ovf updated; done_id = owner.
  - last_served <= owner.
  - Next edge: state <= IDLE.
  - A new request cannot be accepted on the DONE→IDLE edge; it is accepted on the following edge.
- Timing, with capture edge = edge 0:
  - gnt high in cycle 1.
  - done high in cycle WIDTH+1.
  - Earliest next capture is at edge WIDTH+2.
- Requests during SHIFT/DONE are ignored (they remain pending; the requester keeps req high). Once a requester sees gnt it must drop req or it will be re-arbitrated.
- Operand inputs are don't-care except at the capture edge.
- gnt0/gnt1 are never high together.
- busy is 0 only in IDLE.
- Arithmetic:
  - Results are modulo 2^WIDTH; no saturation.
  - Subtract is two's complement: A + ~B + 1.
- sum, cout, ovf and done_id change only in DONE or on reset.

Test Plan:
- req0, a0=100, b0=27, sub0=0 → gnt0 in cycle 1, busy cycles 1–9, done in cycle 9, sum=127, cout=0, ovf=0, done_id=0.
- req1, a1=5, b1=7, sub1=1 → done with sum=0xFE, cout=0, ovf=0, done_id=1. Then a1=7, b1=5, sub1=1 → sum=2, cout=1.
- Overflow and carry:
  - 127+1 → sum=0x80, ovf=1, cout=0.
  - 255+1 → sum=0x00, cout=1, ovf=0.
  - 0x80 − 1 → sum=0x7F, ovf=1.
- Fairness: req0 and req1 held continuously (each dropped one cycle after its gnt, then reasserted) → grant order 0,1,0,1. Each gnt follows the prior done by 2 cycles. gnt0 and gnt1 are never simultaneous.
- Late request: req1 asserted in cycle 3 of a requester 0 operation → ignored until IDLE, then gnt1 two cycles after done.
- Reset mid-op: reset low in cycle 4 of a 100+27 operation → all outputs 0 immediately, no done. After release with req0 still high → fresh gnt0, and the full operation completes with sum=127.

Source files
------------

// File: rtl/bit_serial_sched.sv
// bit_serial_sched: round-robin arbiter plus sequencer for a shared bit-serial
// add/subtract datapath. The winner's operands are captured, WIDTH LSB-first
// serial steps are run through an internal 1-bit full adder, and done pulses
// with the result and owner ID. All outputs are registered.
module bit_serial_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, owner_q, owner_d, last_q, last_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
  logic             done_q, done_d, done_id_q, done_id_d, cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             win, sub_w, s_bit, maj;
  logic [WIDTH-1:0] a_w, b_w, s_next;

  // Next-state: arbitration in IDLE, one full-adder step per SHIFT cycle,
  // and result publication on the final shift so done lines up with DONE.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    owner_d   = owner_q;
    last_d    = last_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    // A tie goes to whoever was not served last; otherwise the sole requester.
    win       = (req0 & req1) ? ~last_q : req1;
    a_w       = win ? a1 : a0;
    b_w       = win ? b1 : b0;
    sub_w     = win ? sub1 : sub0;
    s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
    maj       = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    s_next    = {s_bit, s_q[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // Subtract is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = a_w;
          b_d     = sub_w ? ~b_w : b_w;
          carry_d = sub_w;
          s_d     = '0;
          cnt_d   = '0;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = maj;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = s_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB here, maj the carry out.
          sum_d     = s_next;
          cout_d    = maj;
          ovf_d     = carry_q ^ maj;
          done_id_d = owner_q;
          last_d    = owner_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bit_serial_sched.sv
// tb_bit_serial_sched: scenario tasks driving bit_serial_sched, with results
// checked against an arithmetic reference model (integer add/sub, signed range).
module tb_bit_serial_sched;
  localparam int W = 8;

  logic         clk = 1'b0, reset = 1'b0;
  logic         req0 = 0, sub0 = 0, req1 = 0, sub1 = 0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id, cout, ovf;
  logic [W-1:0] sum;
  int           cyc = 0, total = 0, bad = 0;

  bit_serial_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, unsigned carry and signed range check.
  function automatic void model(input logic [W-1:0] a, b, input bit sub,
                                output logic [W-1:0] s, output logic c, o);
    int ia = int'(a), ib = int'(b);
    int sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
    int sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
    int r  = sub ? ia - ib : ia + ib;
    int sr = sub ? sa - sb : sa + sb;
    s = W'(r & ((1 << W) - 1));
    c = sub ? (ia >= ib) : (r >= (1 << W));
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endfunction

  // Issue one request and collect grant/done observations (no checking here).
  task automatic do_op(input bit id, input logic [W-1:0] a, b, input bit sub,
                       output int gc, dc, output logic [W-1:0] s,
                       output logic c, o, di, output bit to, hs);
    gc = -1; dc = -1; to = 0; hs = 0; s = '0; c = 0; o = 0; di = 0;
    if (id) begin a1 = a; b1 = b; sub1 = sub; req1 = 1; end
    else    begin a0 = a; b0 = b; sub0 = sub; req0 = 1; end
    for (int n = 0; n < 40 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        gc = cyc;
        if ((gnt0 & gnt1) || (id ? gnt0 : gnt1) || !busy) hs = 1;
        req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    if (gc < 0) begin to = 1; return; end
    for (int n = 0; n < 40 && dc < 0; n++) begin
      @(negedge clk);
      if (!busy || gnt0 || gnt1) hs = 1;
      if (done) begin dc = cyc; s = sum; c = cout; o = ovf; di = done_id; end
    end
    if (dc < 0) to = 1;
  endtask

  task automatic test_reset();
    int gc = -1;
    reset = 0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({gnt0, gnt1, busy, done, done_id, sum, cout, ovf} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %0h exp 0",
                      {gnt0, gnt1, busy, done, done_id, sum, cout, ovf});
    end
    reset = 1;
    // First tie after reset must go to requester 0.
    a0 = 8'd3; b0 = 8'd4; sub0 = 0; a1 = 8'd9; b1 = 8'd1; sub1 = 0;
    req0 = 1; req1 = 1;
    for (int n = 0; n < 20 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        gc = cyc;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
          bad++; $display("FAIL first_tie: got gnt0/1=%b exp 10", {gnt0, gnt1});
        end
        req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    total++;
    if (gc < 0) begin bad++; $display("FAIL first_tie_timeout: got none exp gnt"); end
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    total++;
    if (!done || sum !== 8'd7) begin
      bad++; $display("FAIL first_tie_sum: got done=%b sum=%0d exp 7", done, sum);
    end
  endtask

  task automatic test_basic();
    int gc, dc; logic [W-1:0] s; logic c, o, di; bit to, hs;
    do_op(0, 8'd100, 8'd27, 0, gc, dc, s, c, o, di, to, hs);
    total++;
    if (to || hs) begin bad++; $display("FAIL basic_handshake: got to=%b hs=%b exp 0 0", to, hs); end
    total++;
    if (dc - gc != W) begin bad++; $display("FAIL basic_latency: got %0d exp %0d", dc - gc, W); end
    total++;
    if ({s, c, o, di} !== {8'd127, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL basic_result: got sum=%0d c=%b o=%b id=%b exp 127 0 0 0", s, c, o, di);
    end
    @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0 || sum !== 8'd127) begin
      bad++; $display("FAIL basic_after: got busy=%b done=%b sum=%0d exp 0 0 127", busy, done, sum);
    end
  endtask

  // Directed subtract and overflow/carry corners, then random operations.
  task automatic test_arith();
    logic [W-1:0] ta[5] = '{8'd5, 8'd7, 8'd127, 8'd255, 8'h80};
    logic [W-1:0] tb[5] = '{8'd7, 8'd5, 8'd1, 8'd1, 8'd1};
    bit           ts[5] = '{1, 1, 0, 0, 1};
    bit           ti[5] = '{1, 1, 0, 0, 0};
    int gc, dc; logic [W-1:0] s, es; logic c, o, di, ec, eo; bit to, hs;
    logic [W-1:0] ra, rb; bit rs, rid;
    for (int i = 0; i < 29; i++) begin
      if (i < 5) begin ra = ta[i]; rb = tb[i]; rs = ts[i]; rid = ti[i]; end
      else begin
        ra = W'($urandom); rb = W'($urandom);
        rs = 1'($urandom_range(0, 1)); rid = 1'($urandom_range(0, 1));
      end
      model(ra, rb, rs, es, ec, eo);
      do_op(rid, ra, rb, rs, gc, dc, s, c, o, di, to, hs);
      total++;
      if (to || hs || dc - gc != W) begin
        bad++; $display("FAIL arith_timing[%0d]: got to=%b hs=%b lat=%0d exp 0 0 %0d",
                        i, to, hs, dc - gc, W);
      end
      total++;
      if ({s, c, o, di} !== {es, ec, eo, rid}) begin
        bad++; $display("FAIL arith_result[%0d] %0d %s %0d: got sum=%0h c=%b o=%b id=%b exp %0h %b %b %b",
                        i, ra, rs ? "-" : "+", rb, s, c, o, di, es, ec, eo, rid);
      end
    end
  endtask

  task automatic test_fairness();
    logic [W+2:0] expq[$];
    int last_done = -1, ndone = 0, ngnt = 0;
    bit r0 = 0, r1 = 0;
    logic [W-1:0] es; logic ec, eo;
    @(negedge clk); reset = 0; @(negedge clk); reset = 1;
    a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom_range(0, 1));
    a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom_range(0, 1));
    req0 = 1; req1 = 1;
    for (int n = 0; n < 200 && ndone < 4; n++) begin
      @(negedge clk);
      if (r0) begin req0 = 1; r0 = 0; end
      if (r1) begin req1 = 1; r1 = 0; end
      total++;
      if (gnt0 & gnt1) begin bad++; $display("FAIL fair_both_gnt: got 11 exp at most one"); end
      if (gnt0 | gnt1) begin
        model(gnt1 ? a1 : a0, gnt1 ? b1 : b0, gnt1 ? sub1 : sub0, es, ec, eo);
        expq.push_back({gnt1, es, ec, eo});
        total++;
        if (gnt1 !== 1'(ngnt % 2)) begin
          bad++; $display("FAIL fair_order[%0d]: got gnt1=%b exp %b", ngnt, gnt1, 1'(ngnt % 2));
        end
        if (last_done >= 0) begin
          total++;
          if (cyc - last_done != 2) begin
            bad++; $display("FAIL fair_gap[%0d]: got %0d exp 2", ngnt, cyc - last_done);
          end
        end
        ngnt++;
        if (gnt0) begin req0 = 0; r0 = 1; a0 = W'($urandom); b0 = W'($urandom); end
        else      begin req1 = 0; r1 = 1; a1 = W'($urandom); b1 = W'($urandom); end
      end
      if (done) begin
        last_done = cyc; ndone++;
        total++;
        if (expq.size() == 0 || {done_id, sum, cout, ovf} !== expq[0]) begin
          bad++; $display("FAIL fair_result[%0d]: got %0h exp %0h", ndone,
                          {done_id, sum, cout, ovf}, expq.size() ? expq[0] : '0);
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
    end
    req0 = 0; req1 = 0;
    total++;
    if (ndone < 4) begin bad++; $display("FAIL fair_timeout: got %0d dones exp 4", ndone); end
  endtask

  task automatic test_late();
    int gc = -1, dc = -1, g1 = -1, k = 0; bit early = 0;
    a0 = 8'd100; b0 = 8'd27; sub0 = 0; req0 = 1;
    for (int n = 0; n < 30 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt0) begin gc = cyc; req0 = 0; end
    end
    req0 = 0;
    for (int n = 0; n < 30 && gc >= 0 && dc < 0; n++) begin
      @(negedge clk); k++;
      if (gnt1) early = 1;
      if (k == 2) begin a1 = 8'd200; b1 = 8'd58; sub1 = 1; req1 = 1; end
      if (done) dc = cyc;
    end
    total++;
    if (dc < 0 || early || sum !== 8'd127) begin
      bad++; $display("FAIL late_first: got dc=%0d early=%b sum=%0d exp done, 0, 127", dc, early, sum);
    end
    for (int n = 0; n < 30 && g1 < 0; n++) begin
      @(negedge clk);
      if (gnt1) begin g1 = cyc; req1 = 0; end
    end
    req1 = 0;
    total++;
    if (g1 < 0 || g1 - dc != 2) begin
      bad++; $display("FAIL late_gnt1_gap: got %0d exp 2", g1 - dc);
    end
    for (int n = 0; n < 30 && !done; n++) @(negedge clk);
    total++;
    if (!done || {sum, cout, ovf, done_id} !== {8'd142, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL late_second: got done=%b sum=%0d c=%b o=%b id=%b exp 142 1 0 1",
                      done, sum, cout, ovf, done_id);
    end
  endtask

  task automatic test_reset_midop();
    int gc = -1, g2 = -1; bit spurious = 0;
    a0 = 8'd100; b0 = 8'd27; sub0 = 0; req0 = 1;
    for (int n = 0; n < 30 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt0) gc = cyc;
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 reset = 0;
    #1;
    total++;
    if ({gnt0, gnt1, busy, done, done_id, sum, cout, ovf} !== '0) begin
      bad++; $display("FAIL midop_reset_outputs: got %0h exp 0",
                      {gnt0, gnt1, busy, done, done_id, sum, cout, ovf});
    end
    @(negedge clk); @(negedge clk);
    reset = 1;
    for (int n = 0; n < 30 && g2 < 0; n++) begin
      @(negedge clk);
      if (done) spurious = 1;
      if (gnt0) begin g2 = cyc; req0 = 0; end
    end
    req0 = 0;
    total++;
    if (g2 < 0 || spurious) begin
      bad++; $display("FAIL midop_regrant: got gnt=%0d spurious_done=%b exp gnt, 0", g2, spurious);
    end
    for (int n = 0; n < 30 && !done; n++) @(negedge clk);
    total++;
    if (!done || {sum, cout, ovf, done_id} !== {8'd127, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midop_result: got done=%b sum=%0d exp 127", done, sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_fairness();
    test_late();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
